// File: rtl/scr_pkg.sv
// rtl/scr_pkg.sv - shared constants, FSM states and LFSR step for the scrambler data path
package scr_pkg;

  localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;
  // x^16+x^5+x^4+x^3+1 as taps on s[15], s[4], s[3], s[2]
  localparam logic [15:0] LFSR_TAPS = 16'b1000_0000_0001_1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    SCR  = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/scr_lfsr8.sv
// rtl/scr_lfsr8.sv - 16-bit Fibonacci LFSR unrolled eight steps per byte
// With load set, the keystream is taken from SEED so a frame's first byte can use it directly.
module scr_lfsr8 import scr_pkg::*; #(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] ks
);

  logic [15:0] s;
  logic [15:0] walk;

  always_comb begin
    walk = load ? SEED : s;
    ks   = '0;
    for (int k = 0; k < 8; k++) begin
      ks[k] = walk[15];
      walk  = lfsr_step(walk);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        s <= SEED;
    else if (advance) s <= walk;
    else if (load)    s <= SEED;
  end

endmodule

// File: rtl/scr_data_path.sv
// rtl/scr_data_path.sv - per-frame byte scrambler with leading pass-through region
// One-deep registered stage; in_ready is combinational backpressure from the output register.
module scr_data_path import scr_pkg::*; #(
  parameter logic [15:0] SEED  = SEED_DEFAULT,
  parameter int          CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scr_choose,
  input  logic [7:0] unscr_length,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       frame_err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cfg_scr;
  logic [7:0]       cfg_len;
  logic             accept, is_scr, err, lfsr_load, lfsr_adv;
  logic [7:0]       ks;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  scr_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .ks      (ks)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cfg_scr   <= 1'b0;
      cfg_len   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= err;
      // cnt holds the index of the byte about to be accepted
      if (accept) begin
        if (in_sof) begin
          cfg_scr <= scr_choose;
          cfg_len <= unscr_length;
          cnt     <= CNT_W'(1);
        end else if (state != IDLE && cnt != '1) begin
          cnt <= cnt + CNT_W'(1);
        end
        out_valid <= 1'b1;
        out_data  <= in_data ^ (is_scr ? ks : 8'h00);
        out_sof   <= in_sof;
        out_eof   <= in_eof;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_sof) begin
        if (in_eof)                   state_nxt = IDLE;
        else if (unscr_length > 8'd1) state_nxt = PASS;
        else                          state_nxt = SCR;
      end else if (state != IDLE) begin
        if (in_eof)
          state_nxt = IDLE;
        else if (state == PASS && cnt == CNT_W'(cfg_len) - CNT_W'(1))
          state_nxt = SCR;
      end
    end
  end

  always_comb begin
    err       = 1'b0;
    is_scr    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    if (accept) begin
      if (in_sof) begin
        err       = (state != IDLE);
        lfsr_load = 1'b1;
        is_scr    = scr_choose && (unscr_length == 8'd0);
      end else if (state == IDLE) begin
        err = 1'b1;
      end else begin
        is_scr = cfg_scr && (state == SCR);
      end
      lfsr_adv = is_scr;
    end
  end

endmodule
